// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side (IFU/LSU) and downstream memory-bus signals of mem_port_arbiter.
// The arbiter connects through the slave modport; the surrounding environment uses master.
interface mem_port_arbiter_if;
   logic        ifu_req_valid;
   logic        ifu_req_ready;
   logic [63:0] ifu_req_addr;
   logic        ifu_rsp_valid;
   logic [63:0] ifu_rsp_data;
   logic        ifu_rsp_err;

   logic        lsu_req_valid;
   logic        lsu_req_ready;
   logic [63:0] lsu_req_addr;
   logic        lsu_req_wen;
   logic [63:0] lsu_req_wdata;
   logic [7:0]  lsu_req_wstrb;
   logic        lsu_rsp_valid;
   logic [63:0] lsu_rsp_data;
   logic        lsu_rsp_err;

   logic        m_req_valid;
   logic        m_req_ready;
   logic [3:0]  m_req_id;
   logic [63:0] m_req_addr;
   logic        m_req_wen;
   logic [63:0] m_req_wdata;
   logic [7:0]  m_req_wstrb;
   logic [2:0]  m_req_size;
   logic        m_rsp_valid;
   logic [3:0]  m_rsp_id;
   logic [63:0] m_rsp_data;
   logic        m_rsp_err;

   modport slave (
      input  ifu_req_valid, ifu_req_addr,
      output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
      input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
      output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
      output m_req_valid, m_req_id, m_req_addr, m_req_wen, m_req_wdata, m_req_wstrb, m_req_size,
      input  m_req_ready, m_rsp_valid, m_rsp_id, m_rsp_data, m_rsp_err
   );

   modport master (
      output ifu_req_valid, ifu_req_addr,
      input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err,
      output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb,
      input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err,
      input  m_req_valid, m_req_id, m_req_addr, m_req_wen, m_req_wdata, m_req_wstrb, m_req_size,
      output m_req_ready, m_rsp_valid, m_rsp_id, m_rsp_data, m_rsp_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing the memory-bus master port between IFU and LSU, with response watchdog.
// Define ARB_ROUND_ROBIN_EN for 2-entry round-robin tie breaking; otherwise LSU has fixed priority.
//
// state     | meaning
// ST_IDLE   | no transaction; grant a pending requester and latch its request
// ST_REQ    | m_req_valid high, fields held until m_req_ready
// ST_RESP   | waiting for a response with the latched ID, watchdog counting
module mem_port_arbiter #(
   parameter int         TIMEOUT_CYC = 1024,
   parameter logic [3:0] ID_IFU      = 4'h0,
   parameter logic [3:0] ID_LSU      = 4'h1
) (
   input  logic clk,
   input  logic rstn,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              gnt_lsu_q, gnt_lsu_d;
   logic [3:0]        id_q, id_d;
   logic [63:0]       addr_q, addr_d;
   logic              wen_q, wen_d;
   logic [63:0]       wdata_q, wdata_d;
   logic [7:0]        wstrb_q, wstrb_d;
   logic [2:0]        size_q, size_d;

   logic              pick_lsu;
   logic              pick_ifu;
   logic              any_req;
   logic              ifu_ready;
   logic              lsu_ready;
   logic              req_valid;
   logic              rsp_hit;
   logic              rsp_fire;
   logic              rsp_forced;
   logic              ifu_fire;
   logic              lsu_fire;

   // Smallest AxSIZE that covers the number of enabled byte lanes.
   function automatic logic [2:0] strb_size(input logic [7:0] s);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'd0, s[i]};
      if (n <= 4'd1)      strb_size = 3'd0;
      else if (n == 4'd2) strb_size = 3'd1;
      else if (n <= 4'd4) strb_size = 3'd2;
      else                strb_size = 3'd3;
   endfunction

   assign any_req = bus.ifu_req_valid || bus.lsu_req_valid;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_lsu_q, last_lsu_d;

   // On a tie the requester that won last time yields.
   assign pick_lsu = bus.lsu_req_valid && !(bus.ifu_req_valid && last_lsu_q);

   always_comb begin
      last_lsu_d = last_lsu_q;
      if (state_q == ST_IDLE && any_req) last_lsu_d = pick_lsu;
   end

   always_ff @(posedge clk) begin
      if (!rstn) last_lsu_q <= 1'b0;
      else       last_lsu_q <= last_lsu_d;
   end
`else
   assign pick_lsu = bus.lsu_req_valid;
`endif

   assign pick_ifu = bus.ifu_req_valid && !pick_lsu;
   assign rsp_hit  = bus.m_rsp_valid && (bus.m_rsp_id == id_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gnt_lsu_d  = gnt_lsu_q;
      id_d       = id_q;
      addr_d     = addr_q;
      wen_d      = wen_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      size_d     = size_q;
      ifu_ready  = 1'b0;
      lsu_ready  = 1'b0;
      req_valid  = 1'b0;
      rsp_fire   = 1'b0;
      rsp_forced = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pick_lsu) begin
               lsu_ready = 1'b1;
               gnt_lsu_d = 1'b1;
               id_d      = ID_LSU;
               addr_d    = bus.lsu_req_addr;
               wen_d     = bus.lsu_req_wen;
               wdata_d   = bus.lsu_req_wdata;
               wstrb_d   = bus.lsu_req_wstrb;
               size_d    = strb_size(bus.lsu_req_wstrb);
               state_d   = ST_REQ;
            end else if (pick_ifu) begin
               ifu_ready = 1'b1;
               gnt_lsu_d = 1'b0;
               id_d      = ID_IFU;
               addr_d    = bus.ifu_req_addr;
               wen_d     = 1'b0;
               wdata_d   = 64'd0;
               wstrb_d   = 8'h0F;
               size_d    = 3'd2;
               state_d   = ST_REQ;
            end
         end

         ST_REQ: begin
            req_valid = 1'b1;
            if (bus.m_req_ready) begin
               cnt_d   = '0;
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            // A matching response on the watchdog's last cycle takes precedence.
            if (rsp_hit) begin
               rsp_fire = 1'b1;
               state_d  = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               rsp_fire   = 1'b1;
               rsp_forced = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         gnt_lsu_q <= 1'b0;
         id_q      <= 4'd0;
         addr_q    <= 64'd0;
         wen_q     <= 1'b0;
         wdata_q   <= 64'd0;
         wstrb_q   <= 8'd0;
         size_q    <= 3'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_lsu_q <= gnt_lsu_d;
         id_q      <= id_d;
         addr_q    <= addr_d;
         wen_q     <= wen_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         size_q    <= size_d;
      end
   end

   assign ifu_fire = rsp_fire && !gnt_lsu_q;
   assign lsu_fire = rsp_fire && gnt_lsu_q;

   assign bus.ifu_req_ready = ifu_ready;
   assign bus.lsu_req_ready = lsu_ready;

   assign bus.m_req_valid = req_valid;
   assign bus.m_req_id    = id_q;
   assign bus.m_req_addr  = addr_q;
   assign bus.m_req_wen   = wen_q;
   assign bus.m_req_wdata = wdata_q;
   assign bus.m_req_wstrb = wstrb_q;
   assign bus.m_req_size  = size_q;

   // Response data is zero unless a real read completes; writes return no data.
   assign bus.ifu_rsp_valid = ifu_fire;
   assign bus.ifu_rsp_data  = (ifu_fire && !rsp_forced) ? bus.m_rsp_data : 64'd0;
   assign bus.ifu_rsp_err   = ifu_fire && (rsp_forced || bus.m_rsp_err);

   assign bus.lsu_rsp_valid = lsu_fire;
   assign bus.lsu_rsp_data  = (lsu_fire && !rsp_forced && !wen_q) ? bus.m_rsp_data : 64'd0;
   assign bus.lsu_rsp_err   = lsu_fire && (rsp_forced || bus.m_rsp_err);

endmodule
